// File: rtl/cpu_pkg.sv
// cpu_pkg: shared defaults, FSM states and hazard-cause encoding for the issue controller
package cpu_pkg;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_MAX_INFLIGHT = 4;
  typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;
  typedef enum logic [2:0] {NONE, RAW_A, RAW_B, WAW, FULL} hazard_cause_t;
endpackage

// File: rtl/pending_counter_bank.sv
// pending_counter_bank: per-register pending-write counters with reserve, retire and clear
module pending_counter_bank
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc_en,
  input  logic [ADDR_W-1:0]      inc_addr,
  input  logic                   dec_en,
  input  logic [ADDR_W-1:0]      dec_addr,
  input  logic                   clr,
  output logic [NUM_REGS*CW-1:0] cnt_flat,
  output logic [NUM_REGS-1:0]    mask,
  output logic [CW-1:0]          total,
  output logic                   err
);
  logic [CW-1:0] cnt_arr [NUM_REGS];
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    logic [CW-1:0] cnt;
    logic inc_i, dec_i;
    assign inc_i = inc_en && inc_addr == ADDR_W'(i);
    assign dec_i = dec_en && dec_addr == ADDR_W'(i) && cnt != '0;
    always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc_i && !dec_i) cnt <= cnt + CW'(1);
      else if (dec_i && !inc_i) cnt <= cnt - CW'(1);
    assign cnt_arr[i] = cnt;
    assign cnt_flat[i*CW +: CW] = cnt;
    assign mask[i] = cnt != '0;
  end
  always_comb begin
    total = '0;
    for (int k = 0; k < NUM_REGS; k++) total = total + cnt_arr[k];
  end
  // a retire against an empty counter means the write-back stream is out of sync
  always_ff @(posedge clk or posedge reset)
    if (reset) err <= 1'b0;
    else if (dec_en && !clr && cnt_arr[dec_addr] == '0) err <= 1'b1;
endmodule

// File: rtl/issue_hazard_ctrl.sv
// issue_hazard_ctrl: holds one fetched instruction and releases it to ID once free of RAW/WAW/occupancy hazards
module issue_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int STALL_W = 16,
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_req,
  output logic                in_ack,
  input  logic [ADDR_W-1:0]   in_rd,
  input  logic [ADDR_W-1:0]   in_rs1,
  input  logic [ADDR_W-1:0]   in_rs2,
  input  logic                in_writes_rd,
  input  logic                in_uses_rs1,
  input  logic                in_uses_rs2,
  output logic                issue_req,
  input  logic                issue_ack,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CW-1:0]       inflight,
  output logic [STALL_W-1:0]  stall_count,
  output logic                wb_err
);
  state_t state, state_nx;
  hazard_cause_t cause;
  logic [ADDR_W-1:0] rd, rs1, rs2;
  logic writes_rd, uses_rs1, uses_rs2;
  logic accept, hazard, reserve, stall;
  logic [NUM_REGS*CW-1:0] cnt_flat;
  logic [CW-1:0] cnt_arr [NUM_REGS];
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_unpack
    assign cnt_arr[i] = cnt_flat[i*CW +: CW];
  end
  // in_req is still high during the in_ack cycle, so that cycle must not re-latch it
  assign accept = state == IDLE && in_req && !in_ack;
  always_ff @(posedge clk)
    if (accept) begin
      rd <= in_rd;
      rs1 <= in_rs1;
      rs2 <= in_rs2;
      writes_rd <= in_writes_rd;
      uses_rs1 <= in_uses_rs1;
      uses_rs2 <= in_uses_rs2;
    end
  always_comb begin
    cause = (uses_rs1 && cnt_arr[rs1] != '0) ? RAW_A :
            (uses_rs2 && cnt_arr[rs2] != '0) ? RAW_B :
            (writes_rd && cnt_arr[rd] != '0) ? WAW :
            (writes_rd && inflight == CW'(MAX_INFLIGHT)) ? FULL : NONE;
  end
  assign hazard = cause != NONE;
  assign reserve = state == CHECK && !hazard && writes_rd && !flush;
  assign stall = state == CHECK && hazard && stall_count != '1;
  assign issue_req = state == ISSUE;
  always_comb begin
    state_nx = flush ? IDLE :
               accept ? CHECK :
               (state == CHECK && !hazard) ? ISSUE :
               (state == ISSUE && issue_ack) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      in_ack <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      in_ack <= state == ISSUE && issue_ack && !flush;
      if (stall) stall_count <= stall_count + STALL_W'(1);
    end
  pending_counter_bank #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W(ADDR_W),
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_bank (
    .clk(clk),
    .reset(reset),
    .inc_en(reserve),
    .inc_addr(rd),
    .dec_en(wb_valid),
    .dec_addr(wb_addr),
    .clr(flush),
    .cnt_flat(cnt_flat),
    .mask(pending_mask),
    .total(inflight),
    .err(wb_err)
  );
endmodule
